regfile_scoreboard: RTL and testbench

//  32x32 integer register file that receives writeback (data_wb/RegWrite/RegDest) and serves decode.
//  Two combinational read ports. One write port, written on the clock edge.
//  Per-register pending-write scoreboard: decode marks rd on issue, writeback clears it.

---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 86 ++++++++
 tb/tb_regfile_scoreboard.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for regfile_scoreboard: writeback port, two read ports,
// issue handshake and scoreboard status.
interface regfile_scoreboard_if;
    logic        wb_RegWrite;
    logic [4:0]  wb_RegDest;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        iss_valid;
    logic        iss_RegWrite;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        hazard;
    logic [31:0] pending;
    logic        err;

    modport master (
        output wb_RegWrite, wb_RegDest, wb_data, rs1_addr, rs2_addr,
        output iss_valid, iss_RegWrite, iss_rd,
        input  rs1_data, rs2_data, iss_ready, hazard, pending, err
    );

    modport slave (
        input  wb_RegWrite, wb_RegDest, wb_data, rs1_addr, rs2_addr,
        input  iss_valid, iss_RegWrite, iss_rd,
        output rs1_data, rs2_data, iss_ready, hazard, pending, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with a per-register pending-write scoreboard driving decode stall
// and issue back-pressure. Define REGFILE_BYPASS_EN for write-first writeback bypass.
module regfile_scoreboard #(
    parameter int unsigned PEND_W = 2
) (
    input logic               clk,
    input logic               rst,
    regfile_scoreboard_if.slave bus
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [31:0]       regs_q [32];
    logic [PEND_W-1:0] cnt_q  [32];
    logic [PEND_W-1:0] cnt_d  [32];
    logic              err_q, err_d;
    logic              hit1, hit2;
    logic              haz1, haz2;
    logic              sat_block;
    logic              fire;
    logic              inc, dec;

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        hit1 = bus.wb_RegWrite && (bus.wb_RegDest == bus.rs1_addr);
        hit2 = bus.wb_RegWrite && (bus.wb_RegDest == bus.rs2_addr);
`else
        hit1 = 1'b0;
        hit2 = 1'b0;
`endif
        bus.rs1_data = (bus.rs1_addr == 5'd0) ? 32'd0 :
                       (hit1 ? bus.wb_data : regs_q[bus.rs1_addr]);
        bus.rs2_data = (bus.rs2_addr == 5'd0) ? 32'd0 :
                       (hit2 ? bus.wb_data : regs_q[bus.rs2_addr]);

        // The final writeback of a source is only forgiven when it is bypassed.
        haz1 = (bus.rs1_addr != 5'd0) && (cnt_q[bus.rs1_addr] != '0) &&
               !(hit1 && cnt_q[bus.rs1_addr] == CNT_ONE);
        haz2 = (bus.rs2_addr != 5'd0) && (cnt_q[bus.rs2_addr] != '0) &&
               !(hit2 && cnt_q[bus.rs2_addr] == CNT_ONE);
        bus.hazard = haz1 || haz2;

        sat_block     = bus.iss_RegWrite && (bus.iss_rd != 5'd0) && (cnt_q[bus.iss_rd] == CNT_MAX);
        bus.iss_ready = !bus.hazard && !sat_block;
        fire          = bus.iss_valid && bus.iss_ready;

        bus.pending = '0;
        for (int i = 1; i < 32; i++) begin
            bus.pending[i] = (cnt_q[i] != '0);
        end
        bus.err = err_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        inc   = 1'b0;
        dec   = 1'b0;
        for (int r = 1; r < 32; r++) begin
            inc = fire && bus.iss_RegWrite && (bus.iss_rd == 5'(r));
            dec = bus.wb_RegWrite && (bus.wb_RegDest == 5'(r)) && (cnt_q[r] != '0);
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        err_d = err_q || (bus.wb_RegWrite && (bus.wb_RegDest != 5'd0) &&
                          (cnt_q[bus.wb_RegDest] == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (bus.wb_RegWrite && (bus.wb_RegDest != 5'd0)) begin
                regs_q[bus.wb_RegDest] <= bus.wb_data;
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: expectations are queued as stimulus is driven
// and compared against the DUT mid-cycle.
module tb_regfile_scoreboard;
    localparam int S_RS1 = 0;
    localparam int S_RS2 = 1;
    localparam int S_HAZ = 2;
    localparam int S_RDY = 3;
    localparam int S_PND = 4;
    localparam int S_ERR = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    regfile_scoreboard_if bus ();

    regfile_scoreboard #(.PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Compare queued expectations against the DUT without waiting for a clock edge.
    task automatic compare_now();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                S_RS1:   obs = bus.rs1_data;
                S_RS2:   obs = bus.rs2_data;
                S_HAZ:   obs = {31'd0, bus.hazard};
                S_RDY:   obs = {31'd0, bus.iss_ready};
                S_PND:   obs = bus.pending;
                default: obs = {31'd0, bus.err};
            endcase
            check_eq(e.tag, obs, e.val);
        end
    endtask

    // Sample at mid-cycle, then advance to just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_now();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_RegWrite  = 1'b0;
        bus.wb_RegDest   = 5'd0;
        bus.wb_data      = 32'd0;
        bus.rs1_addr     = 5'd0;
        bus.rs2_addr     = 5'd0;
        bus.iss_valid    = 1'b0;
        bus.iss_RegWrite = 1'b0;
        bus.iss_rd       = 5'd0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.iss_valid    = 1'b1;
        bus.iss_RegWrite = 1'b1;
        bus.iss_rd       = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_RegWrite = 1'b1;
        bus.wb_RegDest  = rd;
        bus.wb_data     = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: every address reads zero on both ports.
        expect_val("rst_pending", S_PND, 32'd0);
        expect_val("rst_ready", S_RDY, 32'd1);
        expect_val("rst_hazard", S_HAZ, 32'd0);
        expect_val("rst_err", S_ERR, 32'd0);
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = 5'(a);
            bus.rs2_addr = 5'(31 - a);
            expect_val("rst_rs1", S_RS1, 32'd0);
            expect_val("rst_rs2", S_RS2, 32'd0);
            cyc();
        end

        // Write x5 after marking it pending so no underflow occurs.
        idle(); issue(5'd5);
        expect_val("iss5_ready", S_RDY, 32'd1);
        cyc();
        idle(); wb(5'd5, 32'hDEADBEEF);
        expect_val("wb5_pend", S_PND, 32'h0000_0020);
        cyc();
        idle(); bus.rs1_addr = 5'd5;
        expect_val("rd5", S_RS1, 32'hDEADBEEF);
        expect_val("rd5_pend", S_PND, 32'd0);
        expect_val("rd5_haz", S_HAZ, 32'd0);
        cyc();

        // Writes to x0 are dropped and never raise err.
        idle(); wb(5'd0, 32'h1234); bus.rs2_addr = 5'd0;
        expect_val("wbx0_rs2", S_RS2, 32'd0);
        cyc();
        idle(); bus.rs2_addr = 5'd0;
        expect_val("x0_rs2", S_RS2, 32'd0);
        expect_val("x0_err", S_ERR, 32'd0);
        cyc();

        // RAW hazard on x7 and its final writeback cycle.
        idle(); issue(5'd7);
        cyc();
        idle(); bus.rs1_addr = 5'd7;
        expect_val("x7_haz", S_HAZ, 32'd1);
        expect_val("x7_pend", S_PND, 32'h0000_0080);
        expect_val("x7_ready", S_RDY, 32'd0);
        cyc();
        idle(); bus.rs1_addr = 5'd7; wb(5'd7, 32'h55);
`ifdef REGFILE_BYPASS_EN
        expect_val("x7_byp_data", S_RS1, 32'h55);
        expect_val("x7_byp_haz", S_HAZ, 32'd0);
`else
        expect_val("x7_wb_data", S_RS1, 32'd0);
        expect_val("x7_wb_haz", S_HAZ, 32'd1);
`endif
        cyc();
        idle(); bus.rs1_addr = 5'd7;
        expect_val("x7_after_data", S_RS1, 32'h55);
        expect_val("x7_after_haz", S_HAZ, 32'd0);
        expect_val("x7_after_pend", S_PND, 32'd0);
        cyc();

        // Saturate x3 (PEND_W=2 -> max 3 in flight).
        for (int k = 0; k < 3; k++) begin
            idle(); issue(5'd3);
            expect_val("x3_fill_ready", S_RDY, 32'd1);
            cyc();
        end
        idle(); issue(5'd3);
        expect_val("x3_sat_ready", S_RDY, 32'd0);
        cyc();
        idle(); issue(5'd4);
        expect_val("x4_ready", S_RDY, 32'd1);
        cyc();
        // Saturated issue is refused even while x3 is being written back.
        idle(); issue(5'd3); wb(5'd3, 32'h33);
        expect_val("x3_sat_wb_ready", S_RDY, 32'd0);
        expect_val("x3_sat_pend", S_PND, 32'h0000_0018);
        cyc();
        idle(); bus.iss_RegWrite = 1'b1; bus.iss_rd = 5'd3;
        expect_val("x3_unsat_ready", S_RDY, 32'd1);
        cyc();
        idle(); wb(5'd3, 32'h33);
        cyc();
        idle(); wb(5'd3, 32'h34);
        expect_val("x3_last_pend", S_PND, 32'h0000_0018);
        cyc();
        idle(); wb(5'd4, 32'h44);
        expect_val("x4_last_pend", S_PND, 32'h0000_0010);
        cyc();
        idle(); bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;
        expect_val("drain_pend", S_PND, 32'd0);
        expect_val("drain_rs1", S_RS1, 32'h34);
        expect_val("drain_rs2", S_RS2, 32'h44);
        expect_val("drain_err", S_ERR, 32'd0);
        cyc();

        // Same-cycle issue and writeback nets the counter out.
        idle(); issue(5'd9);
        cyc();
        idle(); issue(5'd9); wb(5'd9, 32'h99);
        expect_val("x9_same_ready", S_RDY, 32'd1);
        cyc();
        idle(); bus.rs1_addr = 5'd9;
        expect_val("x9_pend", S_PND, 32'h0000_0200);
        expect_val("x9_data", S_RS1, 32'h99);
        expect_val("x9_haz", S_HAZ, 32'd1);
        cyc();

        // Underflow makes err sticky.
        idle(); wb(5'd12, 32'hC);
        expect_val("uf_err_pre", S_ERR, 32'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            idle(); bus.rs2_addr = 5'd12;
            expect_val("uf_err_sticky", S_ERR, 32'd1);
            expect_val("uf_data", S_RS2, 32'hC);
            expect_val("uf_pend", S_PND, 32'h0000_0200);
            cyc();
        end

        // Asynchronous reset clears state between clock edges.
        idle(); bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd12;
        #2;
        rst = 1'b1;
        #1;
        expect_val("arst_err", S_ERR, 32'd0);
        expect_val("arst_rs1", S_RS1, 32'd0);
        expect_val("arst_rs2", S_RS2, 32'd0);
        expect_val("arst_pend", S_PND, 32'd0);
        expect_val("arst_ready", S_RDY, 32'd1);
        compare_now();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(); bus.rs1_addr = 5'd9;
        expect_val("post_rst_rs1", S_RS1, 32'd0);
        expect_val("post_rst_haz", S_HAZ, 32'd0);
        cyc();

        if (exp_q.size() != 0) begin
            check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
